// File: rtl/scan_mux_sel.sv
// scan_mux_sel: registered CH-way channel selector.
// Manual mode picks the channel named by sel_in. Auto mode scans the
// channels round-robin, staying on each one for a programmable number of
// cycles. Hold freezes the outputs and the scan position. All outputs come
// from registers, so nothing passes combinationally from input to output.
module scan_mux_sel #(
  parameter  int CH      = 4,
  parameter  int W       = 1,
  parameter  int DWELL_W = 8,
  localparam int SW      = $clog2(CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH*W-1:0]     ch_in,
  input  logic [SW-1:0]       sel_in,
  input  logic                mode,
  input  logic [DWELL_W-1:0]  dwell,
  input  logic                hold,
  output logic [W-1:0]        y,
  output logic [SW-1:0]       y_ch,
  output logic                y_valid,
  output logic                ch_wrap,
  output logic                sel_err
);

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_SCAN   = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t              state;
  logic [SW-1:0]       idx;
  logic [DWELL_W-1:0]  cnt;
  logic                sel_ok;

  // Last count value of a dwell period. A dwell of 0 behaves like 1, so the
  // result is never below 0 and cnt can never pass 2^DWELL_W-2.
  function automatic logic [DWELL_W-1:0] dwell_last(input logic [DWELL_W-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

  // Next scan position. It wraps CH-1 -> 0 and also works when CH is not a
  // power of two.
  function automatic logic [SW-1:0] idx_next(input logic [SW-1:0] i);
    return (i == SW'(CH - 1)) ? '0 : i + 1'b1;
  endfunction

  // Pull channel k out of the packed bus. An index outside the channel
  // range returns zero, but callers never pass one.
  function automatic logic [W-1:0] pick(input logic [CH*W-1:0] bus,
                                        input logic [SW-1:0]   k);
    logic [W-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      if (k == SW'(c)) r = bus[c*W +: W];
    end
    return r;
  endfunction

  // Each cycle the operating state is decoded from hold and mode. Only
  // idx and cnt carry any history.
  always_comb begin
    state  = ST_MANUAL;
    sel_ok = (int'(sel_in) < CH);
    if (hold)      state = ST_HOLD;
    else if (mode) state = ST_SCAN;
  end

  // Output and scan registers. Reset has priority over every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= '0;
      y_ch    <= '0;
      y_valid <= 1'b0;
      ch_wrap <= 1'b0;
      sel_err <= 1'b0;
      idx     <= '0;
      cnt     <= '0;
    end else begin
      unique case (state)
        ST_HOLD: begin
          y_valid <= 1'b0;
          ch_wrap <= 1'b0;
        end
        ST_SCAN: begin
          y       <= pick(ch_in, idx);
          y_ch    <= idx;
          y_valid <= 1'b1;
          sel_err <= 1'b0;
          // Strobe when the reported channel drops from the top index to 0.
          ch_wrap <= (idx == '0) && (y_ch == SW'(CH - 1));
          // Use >= so that a dwell lowered mid-period advances on the next edge.
          if (cnt >= dwell_last(dwell)) begin
            cnt <= '0;
            idx <= idx_next(idx);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (sel_ok) begin
            y       <= pick(ch_in, sel_in);
            y_ch    <= sel_in;
            y_valid <= 1'b1;
            sel_err <= 1'b0;
          end else begin
            y_valid <= 1'b0;
            sel_err <= 1'b1;
          end
          ch_wrap <= 1'b0;
          // Clear the scan position so the next entry into scan starts at channel 0.
          idx     <= '0;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_mux_sel.sv
// Bench for scan_mux_sel. It drives two instances: CH=4/W=1 and CH=3/W=2.
// A behavioural model predicts every output each cycle, and literal
// expectations pin down the directed scenarios.
module tb_scan_mux_sel;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: CH=4, W=1
  logic       rst_a = 1'b1, mode_a = 1'b1, hold_a = 1'b0;
  logic [3:0] ch_in_a = 4'hF;
  logic [1:0] sel_a = 2'd0;
  logic [7:0] dwell_a = 8'd0;
  logic       y_a, yv_a, wrap_a, err_a;
  logic [1:0] ych_a;

  // Instance B: CH=3, W=2
  logic       rst_b = 1'b1, mode_b = 1'b0, hold_b = 1'b0;
  logic [5:0] ch_in_b = 6'h3F;
  logic [1:0] sel_b = 2'd0;
  logic [7:0] dwell_b = 8'd0;
  logic [1:0] y_b, ych_b;
  logic       yv_b, wrap_b, err_b;

  scan_mux_sel #(.CH(4), .W(1), .DWELL_W(8)) dut_a (
    .clk(clk), .rst(rst_a), .ch_in(ch_in_a), .sel_in(sel_a), .mode(mode_a),
    .dwell(dwell_a), .hold(hold_a), .y(y_a), .y_ch(ych_a), .y_valid(yv_a),
    .ch_wrap(wrap_a), .sel_err(err_a));

  scan_mux_sel #(.CH(3), .W(2), .DWELL_W(8)) dut_b (
    .clk(clk), .rst(rst_b), .ch_in(ch_in_b), .sel_in(sel_b), .mode(mode_b),
    .dwell(dwell_b), .hold(hold_b), .y(y_b), .y_ch(ych_b), .y_valid(yv_b),
    .ch_wrap(wrap_b), .sel_err(err_b));

  int n_chk = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: outputs plus the scan position (channel, cycles spent on it).
  typedef struct {
    int y; int ych; int yv; int wrap; int err; int idx; int cnt;
  } m_t;

  m_t ma = '{0, 0, 0, 0, 0, 0, 0};
  m_t mb = '{0, 0, 0, 0, 0, 0, 0};

  function automatic int chan(logic [63:0] bus, int k, int w);
    logic [63:0] v;
    v = (bus >> (k * w)) & ((64'd1 << w) - 64'd1);
    return int'(v);
  endfunction

  function automatic m_t step(m_t s, bit rst, logic [63:0] bus, int sel, bit mode,
                              int dwell, bit hold, int ch, int w);
    m_t n;
    int dw;
    n = s;
    if (rst) begin
      n = '{0, 0, 0, 0, 0, 0, 0};
    end else if (hold) begin
      n.yv = 0;
      n.wrap = 0;
    end else if (mode) begin
      n.y = chan(bus, s.idx, w);
      n.ych = s.idx;
      n.yv = 1;
      n.err = 0;
      n.wrap = (s.idx == 0 && s.ych == ch - 1) ? 1 : 0;
      dw = (dwell == 0) ? 1 : dwell;
      if (s.cnt + 1 >= dw) begin
        n.cnt = 0;
        n.idx = (s.idx + 1) % ch;
      end else begin
        n.cnt = s.cnt + 1;
      end
    end else begin
      if (sel < ch) begin
        n.y = chan(bus, sel, w);
        n.ych = sel;
        n.yv = 1;
        n.err = 0;
      end else begin
        n.yv = 0;
        n.err = 1;
      end
      n.wrap = 0;
      n.idx = 0;
      n.cnt = 0;
    end
    return n;
  endfunction

  // Advance the model on the same edge where the DUT samples its inputs.
  always @(posedge clk) begin
    ma = step(ma, rst_a, 64'(ch_in_a), int'(sel_a), mode_a, int'(dwell_a), hold_a, 4, 1);
    mb = step(mb, rst_b, 64'(ch_in_b), int'(sel_b), mode_b, int'(dwell_b), hold_b, 3, 2);
  end

  // Compare both instances against the model every cycle, away from the edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      n_chk++;
      if (y_a === 1'(ma.y) && ych_a === 2'(ma.ych) && yv_a === 1'(ma.yv) &&
          wrap_a === 1'(ma.wrap) && err_a === 1'(ma.err))
        n_pass++;
      else
        $display("FAIL model_a t=%0t got y=%0d y_ch=%0d valid=%0b wrap=%0b err=%0b want %0d %0d %0d %0d %0d",
                 $time, y_a, ych_a, yv_a, wrap_a, err_a, ma.y, ma.ych, ma.yv, ma.wrap, ma.err);
      n_chk++;
      if (y_b === 2'(mb.y) && ych_b === 2'(mb.ych) && yv_b === 1'(mb.yv) &&
          wrap_b === 1'(mb.wrap) && err_b === 1'(mb.err))
        n_pass++;
      else
        $display("FAIL model_b t=%0t got y=%0d y_ch=%0d valid=%0b wrap=%0b err=%0b want %0d %0d %0d %0d %0d",
                 $time, y_b, ych_b, yv_b, wrap_b, err_b, mb.y, mb.ych, mb.yv, mb.wrap, mb.err);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_a(string nm, int y, int ych, int yv, int wrap, int err);
    n_chk++;
    if (y_a === 1'(y) && ych_a === 2'(ych) && yv_a === 1'(yv) &&
        wrap_a === 1'(wrap) && err_a === 1'(err))
      n_pass++;
    else
      $display("FAIL %s: got y=%0d y_ch=%0d valid=%0b wrap=%0b err=%0b want %0d %0d %0d %0d %0d",
               nm, y_a, ych_a, yv_a, wrap_a, err_a, y, ych, yv, wrap, err);
  endtask

  task automatic chk_b(string nm, int y, int ych, int yv, int wrap, int err);
    n_chk++;
    if (y_b === 2'(y) && ych_b === 2'(ych) && yv_b === 1'(yv) &&
        wrap_b === 1'(wrap) && err_b === 1'(err))
      n_pass++;
    else
      $display("FAIL %s: got y=%0d y_ch=%0d valid=%0b wrap=%0b err=%0b want %0d %0d %0d %0d %0d",
               nm, y_b, ych_b, yv_b, wrap_b, err_b, y, ych, yv, wrap, err);
  endtask

  initial begin
    logic [3:0] pat;
    int seq3 [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    int seq4 [6]  = '{0, 1, 2, 3, 0, 1};
    int rel  [4]  = '{2, 3, 3, 3};

    // Reset held for two cycles with all-ones data and auto mode selected
    tick();
    tick();
    chk_a("reset_a", 0, 0, 0, 0, 0);
    chk_b("reset_b", 0, 0, 0, 0, 0);
    cmp_en = 1'b1;

    // Manual select
    rst_a = 1'b0; rst_b = 1'b0;
    mode_a = 1'b0; ch_in_a = 4'b1010; sel_a = 2'd1;
    tick();
    chk_a("manual_sel1", 1, 1, 1, 0, 0);
    sel_a = 2'd2;
    tick();
    chk_a("manual_sel2", 0, 2, 1, 0, 0);

    // Scan with dwell 3; data pattern 1010
    pat = 4'b1010;
    mode_a = 1'b1; dwell_a = 8'd3;
    for (int i = 0; i < 13; i++) begin
      tick();
      chk_a($sformatf("scan_dwell3_%0d", i), int'(pat[seq3[i]]), seq3[i], 1,
            (i == 12) ? 1 : 0, 0);
    end

    // Back to manual to clear the scan, then dwell 0 (treated as 1)
    mode_a = 1'b0; sel_a = 2'd0;
    tick();
    mode_a = 1'b1; dwell_a = 8'd0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_a($sformatf("scan_dwell0_%0d", i), int'(pat[seq4[i]]), seq4[i], 1,
            (i == 4) ? 1 : 0, 0);
    end

    // Hold after the second cycle showing channel 2, then release
    mode_a = 1'b0;
    tick();
    mode_a = 1'b1; dwell_a = 8'd3;
    repeat (8) tick();
    chk_a("pre_hold", 0, 2, 1, 0, 0);
    hold_a = 1'b1; ch_in_a = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_a($sformatf("hold_%0d", i), 0, 2, 0, 0, 0);
    end
    hold_a = 1'b0;
    pat = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_a($sformatf("release_%0d", i), int'(pat[rel[i]]), rel[i], 1, 0, 0);
    end

    // CH=3: out-of-range select, then reset in the middle of a scan
    ch_in_b = 6'b11_10_01;
    mode_b = 1'b0; sel_b = 2'd2;
    tick();
    chk_b("b_sel2", 3, 2, 1, 0, 0);
    sel_b = 2'd3;
    tick();
    chk_b("b_sel_err", 3, 2, 0, 0, 1);
    sel_b = 2'd0;
    tick();
    chk_b("b_sel0", 1, 0, 1, 0, 0);
    mode_b = 1'b1; dwell_b = 8'd1;
    tick();
    chk_b("b_scan0", 1, 0, 1, 0, 0);
    tick();
    chk_b("b_scan1", 2, 1, 1, 0, 0);
    rst_b = 1'b1;
    tick();
    chk_b("b_mid_reset", 0, 0, 0, 0, 0);
    rst_b = 1'b0;
    tick();
    chk_b("b_restart", 1, 0, 1, 0, 0);

    // Random traffic checked by the model
    for (int i = 0; i < 4000; i++) begin
      rst_a   = ($urandom_range(0, 99) == 0);
      hold_a  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) mode_a = ~mode_a;
      dwell_a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      sel_a   = 2'($urandom);
      ch_in_a = 4'($urandom);
      rst_b   = ($urandom_range(0, 99) == 0);
      hold_b  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) mode_b = ~mode_b;
      dwell_b = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      sel_b   = 2'($urandom);
      ch_in_b = 6'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
